// File: rtl/riscv_pkg.sv
// Shared RV32I core constants and types.
package riscv_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned NUM_ARCH_REGS = 32;
    localparam int unsigned REG_ADDR_W    = $clog2(NUM_ARCH_REGS);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: range check, hardwired-zero rule and write bypass.
module regfile_read_port
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH    = XLEN,
    parameter int unsigned NUM_REGS = NUM_ARCH_REGS,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic [WIDTH-1:0]  mem [NUM_REGS],
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data
);

    localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

    logic addr_ok;
    logic bypass_hit;

    // An address matching a write is valid for both, so bypass needs no separate write check.
    always_comb begin
        addr_ok    = ({1'b0, rd_addr} < REG_LIMIT) && !(ZERO_REG && (rd_addr == '0));
        bypass_hit = BYPASS && wr_en && !rst && (wr_addr == rd_addr);
        rd_data    = '0;
        if (addr_ok) begin
            rd_data = bypass_hit ? wr_data : mem[rd_addr];
        end
    end

endmodule

// File: rtl/register_file.sv
// Multi-ported integer register file: one synchronous write port, NUM_READ combinational reads.
module register_file
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH    = XLEN,
    parameter int unsigned NUM_REGS = NUM_ARCH_REGS,
    parameter int unsigned NUM_READ = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr [NUM_READ],
    output logic [WIDTH-1:0]  rd_data [NUM_READ]
);

    localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

    logic [WIDTH-1:0] mem_q [NUM_REGS];
    logic [WIDTH-1:0] mem_d [NUM_REGS];
    logic             wr_ok;

    // Out-of-range and zero-register writes are dropped here, so entry 0 never leaves reset value.
    always_comb begin
        wr_ok = wr_en && ({1'b0, wr_addr} < REG_LIMIT) && !(ZERO_REG && (wr_addr == '0));
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
        regfile_read_port #(
            .WIDTH    (WIDTH),
            .NUM_REGS (NUM_REGS),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd (
            .mem     (mem_q),
            .rd_addr (rd_addr[g]),
            .rst     (rst),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_data (rd_data[g])
        );
    end

endmodule
